// File: rtl/alu_operand_sequencer_pkg.sv
// Shared encodings for the ALU front end: sequencer stages and the opcode
// values the ALU decodes.
package alu_operand_sequencer_pkg;

  typedef enum logic [1:0] {
    S_A    = 2'd0,
    S_B    = 2'd1,
    S_OP   = 2'd2,
    S_DONE = 2'd3
  } stage_e;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_AND = 2'd2,
    OP_XOR = 2'd3
  } opcode_e;

  localparam int OPCODE_WIDTH = 2;

endpackage

// File: rtl/alu_operand_sequencer_button_debouncer.sv
// Push-button conditioner: 2-FF synchronizer, stability counter and a
// single-cycle pulse on each accepted press (never on release).
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic CLK,
  input  logic RST,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_pulse
);

  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic          sync_meta_r;
  logic          sync_r;
  logic          stable_r;
  logic [CW-1:0] cnt_r;
  logic          pulse_r;

  // Synchronize the raw pin, then accept a new level only after it has
  // differed from the stable level for DEBOUNCE_CYCLES consecutive cycles.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sync_meta_r <= 1'b0;
      sync_r      <= 1'b0;
      stable_r    <= 1'b0;
      cnt_r       <= {CW{1'b0}};
      pulse_r     <= 1'b0;
    end else begin
      sync_meta_r <= btn_raw;
      sync_r      <= sync_meta_r;
      pulse_r     <= 1'b0;
      if (sync_r != stable_r) begin
        if (cnt_r == CNT_MAX) begin
          stable_r <= sync_r;
          cnt_r    <= {CW{1'b0}};
          pulse_r  <= sync_r;
        end else begin
          cnt_r <= cnt_r + CNT_ONE;
        end
      end else begin
        cnt_r <= {CW{1'b0}};
      end
    end
  end

  assign btn_level = stable_r;
  assign btn_pulse = pulse_r;

endmodule

// File: rtl/alu_operand_sequencer.sv
// Collects operand A, operand B and opcode from the slide switches over three
// debounced ENTER presses and presents them as registered ALU inputs.
module alu_operand_sequencer
  import alu_operand_sequencer_pkg::*;
#(
  parameter int DATA_WIDTH      = 4,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] SW,
  input  logic                  BTN_ENTER,
  input  logic                  BTN_CLEAR,
  output logic [DATA_WIDTH-1:0] A_out,
  output logic [DATA_WIDTH-1:0] B_out,
  output logic [1:0]            opcode_out,
  output logic                  op_valid,
  output logic [1:0]            stage
);

  logic enter_level_s;
  logic enter_pulse_s;
  logic clear_level_s;
  logic clear_pulse_s;

  stage_e                state_r;
  logic [DATA_WIDTH-1:0] a_r;
  logic [DATA_WIDTH-1:0] b_r;
  opcode_e               op_r;
  logic                  valid_r;

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_enter_db (
    .CLK       (CLK),
    .RST       (RST),
    .btn_raw   (BTN_ENTER),
    .btn_level (enter_level_s),
    .btn_pulse (enter_pulse_s)
  );

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear_db (
    .CLK       (CLK),
    .RST       (RST),
    .btn_raw   (BTN_CLEAR),
    .btn_level (clear_level_s),
    .btn_pulse (clear_pulse_s)
  );

  // Capture sequencer; clear has priority so a coincident enter is dropped.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_r <= S_A;
      a_r     <= {DATA_WIDTH{1'b0}};
      b_r     <= {DATA_WIDTH{1'b0}};
      op_r    <= OP_ADD;
      valid_r <= 1'b0;
    end else begin
      valid_r <= 1'b0;
      if (clear_pulse_s) begin
        state_r <= S_A;
        a_r     <= {DATA_WIDTH{1'b0}};
        b_r     <= {DATA_WIDTH{1'b0}};
        op_r    <= OP_ADD;
      end else if (enter_pulse_s) begin
        case (state_r)
          S_A: begin
            a_r     <= SW;
            state_r <= S_B;
          end
          S_B: begin
            b_r     <= SW;
            state_r <= S_OP;
          end
          S_OP: begin
            op_r    <= opcode_e'(SW[1:0]);
            state_r <= S_DONE;
            valid_r <= 1'b1;
          end
          S_DONE: begin
            // New operation: B and opcode stay until overwritten.
            a_r     <= SW;
            state_r <= S_B;
          end
          default: begin
            state_r <= S_A;
          end
        endcase
      end else begin
        state_r <= state_r;
      end
    end
  end

  assign A_out      = a_r;
  assign B_out      = b_r;
  assign opcode_out = op_r;
  assign op_valid   = valid_r;
  assign stage      = state_r;

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Self-checking bench for alu_operand_sequencer with DEBOUNCE_CYCLES=4:
// directed table, hand-written corner sequences, and randomized operations.
module tb_alu_operand_sequencer;

  logic       CLK;
  logic       RST;
  logic [3:0] SW;
  logic       BTN_ENTER;
  logic       BTN_CLEAR;
  logic [3:0] A_out;
  logic [3:0] B_out;
  logic [1:0] opcode_out;
  logic       op_valid;
  logic [1:0] stage;

  int checks;
  int errors;
  int vcnt;

  alu_operand_sequencer #(.DATA_WIDTH(4), .DEBOUNCE_CYCLES(4)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .SW         (SW),
    .BTN_ENTER  (BTN_ENTER),
    .BTN_CLEAR  (BTN_CLEAR),
    .A_out      (A_out),
    .B_out      (B_out),
    .opcode_out (opcode_out),
    .op_valid   (op_valid),
    .stage      (stage)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Count cycles with op_valid high, sampled away from the active edge.
  always @(negedge CLK) begin
    if (op_valid) vcnt <= vcnt + 1;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge CLK);
  endtask

  // Hold the chosen buttons with a stable switch value, release, let the
  // release debounce settle, then wiggle the switches as idle noise.
  task automatic press(input bit do_enter, input bit do_clear,
                       input logic [3:0] sw, input int hold);
    SW        = sw;
    BTN_ENTER = do_enter;
    BTN_CLEAR = do_clear;
    cycles(hold);
    BTN_ENTER = 1'b0;
    BTN_CLEAR = 1'b0;
    cycles(12);
    SW = 4'($urandom);
    cycles(2);
  endtask

  task automatic chk_all(input string tag, input logic [3:0] ea, input logic [3:0] eb,
                         input logic [1:0] eop, input logic [1:0] est,
                         input int ev, input int vstart);
    chk({tag, ".A"},     int'(A_out),      int'(ea));
    chk({tag, ".B"},     int'(B_out),      int'(eb));
    chk({tag, ".OP"},    int'(opcode_out), int'(eop));
    chk({tag, ".STAGE"}, int'(stage),      int'(est));
    chk({tag, ".VALID"}, vcnt - vstart,    ev);
  endtask

  typedef struct {
    logic       enter;
    logic       clear;
    logic [3:0] sw;
    logic [3:0] ea;
    logic [3:0] eb;
    logic [1:0] eop;
    logic [1:0] est;
    int         ev;
  } vec_t;

  vec_t tbl[9];

  // Higher-level reference: n = number of accepted enters since the last
  // clear; the field written is (n-1) mod 3, a set completes every 3rd enter.
  int         m_n;
  logic [3:0] m_a;
  logic [3:0] m_b;
  logic [1:0] m_op;

  initial begin
    int v0;
    checks    = 0;
    errors    = 0;
    vcnt      = 0;
    RST       = 1'b0;
    SW        = 4'h0;
    BTN_ENTER = 1'b0;
    BTN_CLEAR = 1'b0;

    // Reset with no presses.
    cycles(3);
    RST = 1'b1;
    v0 = vcnt;
    cycles(10);
    chk_all("reset", 4'h0, 4'h0, 2'd0, 2'd0, 0, v0);

    // Directed table: full set, restart from S_DONE, clear, partial set.
    tbl[0] = '{1'b1, 1'b0, 4'h5, 4'h5, 4'h0, 2'd0, 2'd1, 0};
    tbl[1] = '{1'b1, 1'b0, 4'h3, 4'h5, 4'h3, 2'd0, 2'd2, 0};
    tbl[2] = '{1'b1, 1'b0, 4'h1, 4'h5, 4'h3, 2'd1, 2'd3, 1};
    tbl[3] = '{1'b1, 1'b0, 4'hF, 4'hF, 4'h3, 2'd1, 2'd1, 0};
    tbl[4] = '{1'b1, 1'b0, 4'h6, 4'hF, 4'h6, 2'd1, 2'd2, 0};
    tbl[5] = '{1'b1, 1'b0, 4'hE, 4'hF, 4'h6, 2'd2, 2'd3, 1};
    tbl[6] = '{1'b0, 1'b1, 4'h9, 4'h0, 4'h0, 2'd0, 2'd0, 0};
    tbl[7] = '{1'b1, 1'b0, 4'hA, 4'hA, 4'h0, 2'd0, 2'd1, 0};
    tbl[8] = '{1'b0, 1'b1, 4'h7, 4'h0, 4'h0, 2'd0, 2'd0, 0};
    for (int i = 0; i < 9; i++) begin
      v0 = vcnt;
      press(tbl[i].enter, tbl[i].clear, tbl[i].sw, 20);
      chk_all($sformatf("tbl%0d", i), tbl[i].ea, tbl[i].eb, tbl[i].eop,
              tbl[i].est, tbl[i].ev, v0);
    end

    // Bouncy ENTER: six 2-cycle toggles then a steady hold -> one advance.
    v0 = vcnt;
    SW = 4'hC;
    for (int t = 0; t < 6; t++) begin
      BTN_ENTER = ~BTN_ENTER;
      cycles(2);
    end
    BTN_ENTER = 1'b1;
    cycles(20);
    BTN_ENTER = 1'b0;
    cycles(12);
    chk_all("bounce", 4'hC, 4'h0, 2'd0, 2'd1, 0, v0);

    // Simultaneous clear and enter from S_OP: clear wins.
    press(1'b0, 1'b1, 4'h0, 20);
    press(1'b1, 1'b0, 4'h9, 20);
    press(1'b1, 1'b0, 4'h2, 20);
    chk("setup.STAGE", int'(stage), 2);
    chk("setup.A", int'(A_out), 9);
    v0 = vcnt;
    press(1'b1, 1'b1, 4'h3, 20);
    chk_all("clr_ent", 4'h0, 4'h0, 2'd0, 2'd0, 0, v0);

    // Reset mid-debounce in S_B; a held button yields one press afterwards.
    press(1'b1, 1'b0, 4'h7, 20);
    chk("pre_rst.STAGE", int'(stage), 1);
    SW        = 4'h4;
    BTN_ENTER = 1'b1;
    cycles(3);
    RST = 1'b0;
    #1;
    chk("rst_mid.A", int'(A_out), 0);
    chk("rst_mid.STAGE", int'(stage), 0);
    @(negedge CLK);
    RST = 1'b1;
    v0 = vcnt;
    cycles(15);
    chk_all("rst_hold", 4'h4, 4'h0, 2'd0, 2'd1, 0, v0);
    cycles(10);
    chk("rst_hold2.STAGE", int'(stage), 1);
    BTN_ENTER = 1'b0;
    cycles(12);

    // Randomized operations against the reference model.
    press(1'b0, 1'b1, 4'h0, 20);
    m_n  = 0;
    m_a  = 4'h0;
    m_b  = 4'h0;
    m_op = 2'd0;
    for (int r = 0; r < 40; r++) begin
      logic [3:0] sw;
      bit         en;
      bit         cl;
      int         ev;
      int         est;
      sw = 4'($urandom);
      cl = ($urandom_range(0, 5) == 0);
      en = cl ? bit'($urandom_range(0, 1)) : 1'b1;
      ev = 0;
      if (cl) begin
        m_n  = 0;
        m_a  = 4'h0;
        m_b  = 4'h0;
        m_op = 2'd0;
      end else begin
        m_n++;
        if ((m_n - 1) % 3 == 0) m_a = sw;
        else if ((m_n - 1) % 3 == 1) m_b = sw;
        else m_op = sw[1:0];
        if (m_n % 3 == 0) ev = 1;
      end
      est = (m_n == 0) ? 0 : ((m_n - 1) % 3) + 1;
      v0 = vcnt;
      press(en, cl, sw, $urandom_range(8, 14));
      chk_all($sformatf("rnd%0d", r), m_a, m_b, m_op, 2'(est), ev, v0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
